// File: rtl/alu_issue_if.sv
// Issue-stage bus: instruction handshake in, ALU operation out, ALU result back.
interface alu_issue_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        stall;
  logic [2:0]  alu_func;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        illegal_instr;
  logic [31:0] retired_count;

  modport slave (
    input  instr_valid, instr, stall, alu_result,
    output instr_ready, alu_func, alu_op1, alu_op2, alu_valid, alu_rd,
           illegal_instr, retired_count
  );

  modport master (
    output instr_valid, instr, stall, alu_result,
    input  instr_ready, alu_func, alu_op1, alu_op2, alu_valid, alu_rd,
           illegal_instr, retired_count
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I ALU issue stage: decode, register-file read with RAW forwarding or
// stall, one-entry issue register, and writeback of the external ALU result.
module alu_issue #(
  parameter int unsigned FORWARD_EN = 1
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);

  logic [31:0] rf_q [32];
  logic        alu_valid_q;
  logic [2:0]  alu_func_q;
  logic [31:0] alu_op1_q, alu_op2_q;
  logic [4:0]  alu_rd_q;
  logic        illegal_q;
  logic [31:0] retired_q;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        is_op, is_imm, legal;
  logic [2:0]  func_d;
  logic        haz1, haz2;
  logic [31:0] rs1_val, rs2_val, op1_d, op2_d;
  logic        accept, wb;

  assign opcode = bus.instr[6:0];
  assign rd     = bus.instr[11:7];
  assign funct3 = bus.instr[14:12];
  assign rs1    = bus.instr[19:15];
  assign rs2    = bus.instr[24:20];
  assign funct7 = bus.instr[31:25];
  assign imm    = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign is_op  = (opcode == 7'b0110011);
  assign is_imm = (opcode == 7'b0010011);

  always_comb begin
    legal  = 1'b0;
    func_d = 3'b000;
    if (is_op) begin
      unique case ({funct7, funct3})
        {7'b0000000, 3'b000}: begin legal = 1'b1; func_d = 3'b000; end
        {7'b0100000, 3'b000}: begin legal = 1'b1; func_d = 3'b001; end
        {7'b0000000, 3'b111}: begin legal = 1'b1; func_d = 3'b010; end
        {7'b0000000, 3'b110}: begin legal = 1'b1; func_d = 3'b011; end
        default: ;
      endcase
    end else if (is_imm) begin
      unique case (funct3)
        3'b000:  begin legal = 1'b1; func_d = 3'b000; end
        3'b111:  begin legal = 1'b1; func_d = 3'b010; end
        3'b110:  begin legal = 1'b1; func_d = 3'b011; end
        default: ;
      endcase
    end
  end

  // rs2 of OP-IMM is immediate bits, never a source register.
  assign haz1 = legal && alu_valid_q && (rs1 != '0) && (rs1 == alu_rd_q);
  assign haz2 = legal && !is_imm && alu_valid_q && (rs2 != '0) && (rs2 == alu_rd_q);

  assign rs1_val = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : rf_q[rs2];
  assign op1_d   = ((FORWARD_EN != 0) && haz1) ? bus.alu_result : rs1_val;
  assign op2_d   = is_imm ? imm :
                   (((FORWARD_EN != 0) && haz2) ? bus.alu_result : rs2_val);

  assign bus.instr_ready = rst_n && !bus.stall &&
                           !((FORWARD_EN == 0) && (haz1 || haz2));
  assign accept = bus.instr_valid && bus.instr_ready;
  assign wb     = alu_valid_q && !bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
      alu_valid_q <= 1'b0;
      alu_func_q  <= '0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_rd_q    <= '0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      illegal_q <= accept && !legal;
      if (wb) begin
        if (alu_rd_q != '0) rf_q[alu_rd_q] <= bus.alu_result;
        retired_q <= retired_q + 32'd1;
      end
      if (accept && legal) begin
        alu_valid_q <= 1'b1;
        alu_func_q  <= func_d;
        alu_op1_q   <= op1_d;
        alu_op2_q   <= op2_d;
        alu_rd_q    <= rd;
      end else if (wb) begin
        alu_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_valid     = alu_valid_q;
  assign bus.alu_func      = alu_func_q;
  assign bus.alu_op1       = alu_op1_q;
  assign bus.alu_op2       = alu_op2_q;
  assign bus.alu_rd        = alu_rd_q;
  assign bus.illegal_instr = illegal_q;
  assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: one forwarding instance and one stalling instance.
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_if a ();
  alu_issue_if b ();

  alu_issue #(.FORWARD_EN(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  alu_issue #(.FORWARD_EN(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  always_comb begin
    a.alu_result = '0;
    case (a.alu_func)
      3'b000: a.alu_result = a.alu_op1 + a.alu_op2;
      3'b001: a.alu_result = a.alu_op1 - a.alu_op2;
      3'b010: a.alu_result = a.alu_op1 & a.alu_op2;
      3'b011: a.alu_result = a.alu_op1 | a.alu_op2;
      default: ;
    endcase
  end

  always_comb begin
    b.alu_result = '0;
    case (b.alu_func)
      3'b000: b.alu_result = b.alu_op1 + b.alu_op2;
      3'b001: b.alu_result = b.alu_op1 - b.alu_op2;
      3'b010: b.alu_result = b.alu_op1 & b.alu_op2;
      3'b011: b.alu_result = b.alu_op1 | b.alu_op2;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] i_op(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  logic [31:0] tab_instr [4];
  logic [2:0]  tab_func  [4];
  logic [31:0] tab_op1   [4];
  logic [31:0] tab_op2   [4];

  initial begin
    a.instr_valid = 1'b0; a.instr = '0; a.stall = 1'b0;
    b.instr_valid = 1'b0; b.instr = '0; b.stall = 1'b0;

    tab_instr[0] = r_op(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd5);    // AND x5,x1,x2
    tab_func[0] = 3'b010; tab_op1[0] = 32'd7; tab_op2[0] = 32'hFFFFFFFD;
    tab_instr[1] = r_op(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd6);    // OR x6,x1,x2
    tab_func[1] = 3'b011; tab_op1[1] = 32'd7; tab_op2[1] = 32'hFFFFFFFD;
    tab_instr[2] = i_op(3'b111, 5'd7, 5'd1, 12'h0F0);             // ANDI x7,x1,0xF0
    tab_func[2] = 3'b010; tab_op1[2] = 32'd7; tab_op2[2] = 32'h000000F0;
    tab_instr[3] = i_op(3'b110, 5'd8, 5'd1, 12'hFFF);             // ORI x8,x1,-1
    tab_func[3] = 3'b011; tab_op1[3] = 32'd7; tab_op2[3] = 32'hFFFFFFFF;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, a.alu_valid}, 32'd0);
    chk("rst_func", {29'd0, a.alu_func}, 32'd0);
    chk("rst_op1", a.alu_op1, 32'd0);
    chk("rst_op2", a.alu_op2, 32'd0);
    chk("rst_rd", {27'd0, a.alu_rd}, 32'd0);
    chk("rst_ill", {31'd0, a.illegal_instr}, 32'd0);
    chk("rst_cnt", a.retired_count, 32'd0);
    chk("rst_ready", {31'd0, a.instr_ready}, 32'd0);

    // ADDI x1,x0,5 ; ADDI x2,x0,-3
    rst_n = 1'b1;
    a.instr_valid = 1'b1;
    a.instr = i_op(3'b000, 5'd1, 5'd0, 12'd5);
    #1 chk("first_ready", {31'd0, a.instr_ready}, 32'd1);
    @(negedge clk);
    chk("addi1_valid", {31'd0, a.alu_valid}, 32'd1);
    chk("addi1_op2", a.alu_op2, 32'h00000005);
    chk("addi1_rd", {27'd0, a.alu_rd}, 32'd1);
    a.instr = i_op(3'b000, 5'd2, 5'd0, 12'hFFD);
    @(negedge clk);
    chk("addi2_op2", a.alu_op2, 32'hFFFFFFFD);
    chk("addi2_cnt", a.retired_count, 32'd1);
    a.instr_valid = 1'b0;
    @(negedge clk);
    chk("pair_cnt", a.retired_count, 32'd2);
    chk("pair_idle", {31'd0, a.alu_valid}, 32'd0);
    chk("x1", dut_a.rf_q[1], 32'd5);
    chk("x2", dut_a.rf_q[2], 32'hFFFFFFFD);

    // forwarding: ADDI x1,x0,7 ; SUB x3,x1,x1
    a.instr_valid = 1'b1;
    a.instr = i_op(3'b000, 5'd1, 5'd0, 12'd7);
    @(negedge clk);
    a.instr = r_op(7'b0100000, 5'd1, 5'd1, 3'b000, 5'd3);
    #1 chk("fwd_nobubble", {31'd0, a.instr_ready}, 32'd1);
    @(negedge clk);
    chk("fwd_op1", a.alu_op1, 32'd7);
    chk("fwd_op2", a.alu_op2, 32'd7);
    chk("fwd_func", {29'd0, a.alu_func}, 32'd1);
    chk("fwd_rd", {27'd0, a.alu_rd}, 32'd3);
    a.instr_valid = 1'b0;
    @(negedge clk);
    chk("fwd_cnt", a.retired_count, 32'd4);
    chk("fwd_x3", dut_a.rf_q[3], 32'd0);
    chk("fwd_x1", dut_a.rf_q[1], 32'd7);

    // decode table, back-to-back
    a.instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a.instr = tab_instr[i];
      @(negedge clk);
      chk($sformatf("dec%0d_func", i), {29'd0, a.alu_func}, {29'd0, tab_func[i]});
      chk($sformatf("dec%0d_op1", i), a.alu_op1, tab_op1[i]);
      chk($sformatf("dec%0d_op2", i), a.alu_op2, tab_op2[i]);
    end
    a.instr_valid = 1'b0;
    @(negedge clk);
    chk("dec_cnt", a.retired_count, 32'd8);
    chk("dec_x5", dut_a.rf_q[5], 32'd5);
    chk("dec_x6", dut_a.rf_q[6], 32'hFFFFFFFF);
    chk("dec_x7", dut_a.rf_q[7], 32'd0);
    chk("dec_x8", dut_a.rf_q[8], 32'hFFFFFFFF);

    // illegal encodings: ECALL, then SUB-funct7 with funct3=111
    a.instr_valid = 1'b1;
    a.instr = 32'h00000073;
    @(negedge clk);
    chk("ecall_ill", {31'd0, a.illegal_instr}, 32'd1);
    chk("ecall_valid", {31'd0, a.alu_valid}, 32'd0);
    a.instr = r_op(7'b0100000, 5'd2, 5'd1, 3'b111, 5'd12);
    @(negedge clk);
    chk("badop_ill", {31'd0, a.illegal_instr}, 32'd1);
    chk("badop_valid", {31'd0, a.alu_valid}, 32'd0);
    a.instr_valid = 1'b0;
    @(negedge clk);
    chk("ill_clear", {31'd0, a.illegal_instr}, 32'd0);
    chk("ill_cnt", a.retired_count, 32'd8);
    chk("ill_x12", dut_a.rf_q[12], 32'd0);

    // stall hold for 3 cycles
    a.instr_valid = 1'b1;
    a.instr = i_op(3'b000, 5'd4, 5'd0, 12'd9);
    @(negedge clk);
    a.stall = 1'b1;
    a.instr = i_op(3'b000, 5'd13, 5'd0, 12'd1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", {31'd0, a.instr_ready}, 32'd0);
      @(negedge clk);
      chk("stall_valid", {31'd0, a.alu_valid}, 32'd1);
      chk("stall_op2", a.alu_op2, 32'd9);
      chk("stall_rd", {27'd0, a.alu_rd}, 32'd4);
      chk("stall_cnt", a.retired_count, 32'd8);
    end
    a.stall = 1'b0;
    @(negedge clk);
    chk("rel_cnt", a.retired_count, 32'd9);
    chk("rel_rd", {27'd0, a.alu_rd}, 32'd13);
    a.instr_valid = 1'b0;
    @(negedge clk);
    chk("rel_cnt2", a.retired_count, 32'd10);
    chk("rel_x4", dut_a.rf_q[4], 32'd9);
    chk("rel_x13", dut_a.rf_q[13], 32'd1);

    // reset with an op in flight
    a.instr_valid = 1'b1;
    a.instr = i_op(3'b000, 5'd14, 5'd0, 12'd11);
    @(negedge clk);
    chk("mid_valid", {31'd0, a.alu_valid}, 32'd1);
    a.instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, a.alu_valid}, 32'd0);
    chk("mid_rst_op2", a.alu_op2, 32'd0);
    chk("mid_rst_rd", {27'd0, a.alu_rd}, 32'd0);
    chk("mid_rst_cnt", a.retired_count, 32'd0);
    chk("mid_rst_ready", {31'd0, a.instr_ready}, 32'd0);
    chk("mid_rst_x4", dut_a.rf_q[4], 32'd0);
    @(negedge clk);
    chk("mid_rst_x14", dut_a.rf_q[14], 32'd0);
    rst_n = 1'b1;

    // stall-on-hazard instance
    b.instr_valid = 1'b1;
    b.instr = i_op(3'b000, 5'd1, 5'd0, 12'd7);
    @(negedge clk);
    chk("b_addi_valid", {31'd0, b.alu_valid}, 32'd1);
    b.instr = r_op(7'b0100000, 5'd1, 5'd1, 3'b000, 5'd3);
    #1 chk("b_haz_ready", {31'd0, b.instr_ready}, 32'd0);
    @(negedge clk);
    chk("b_bubble_valid", {31'd0, b.alu_valid}, 32'd0);
    chk("b_bubble_cnt", b.retired_count, 32'd1);
    chk("b_after_ready", {31'd0, b.instr_ready}, 32'd1);
    @(negedge clk);
    chk("b_sub_op1", b.alu_op1, 32'd7);
    chk("b_sub_op2", b.alu_op2, 32'd7);
    chk("b_sub_func", {29'd0, b.alu_func}, 32'd1);
    b.instr = i_op(3'b000, 5'd9, 5'd0, 12'd3);
    #1 chk("b_immrs2_ready", {31'd0, b.instr_ready}, 32'd1);
    @(negedge clk);
    chk("b_imm_op2", b.alu_op2, 32'd3);
    chk("b_imm_cnt", b.retired_count, 32'd2);
    b.instr = i_op(3'b000, 5'd0, 5'd0, 12'd5);
    @(negedge clk);
    chk("b_x0_rd", {27'd0, b.alu_rd}, 32'd0);
    b.instr = r_op(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd11);
    #1 chk("b_x0_ready", {31'd0, b.instr_ready}, 32'd1);
    @(negedge clk);
    chk("b_add_rd", {27'd0, b.alu_rd}, 32'd11);
    chk("b_add_cnt", b.retired_count, 32'd4);
    b.instr_valid = 1'b0;
    @(negedge clk);
    chk("b_cnt", b.retired_count, 32'd5);
    chk("b_x1", dut_b.rf_q[1], 32'd7);
    chk("b_x3", dut_b.rf_q[3], 32'd0);
    chk("b_x9", dut_b.rf_q[9], 32'd3);
    chk("b_x0", dut_b.rf_q[0], 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
